// File: rtl/apb_req_master.sv
// APB3 initiator: one valid/ready request in, one APB setup/access transaction out, one response back.
// Optional ACCESS-phase timeout is compiled in with `define APB_MST_TIMEOUT_EN.
module apb_req_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_reg, state_next;
    logic                psel_reg, psel_next;
    logic                penable_reg, penable_next;
    logic                pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0]   paddr_reg, paddr_next;
    logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
    logic                rsp_vld_reg, rsp_vld_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                rsp_err_reg, rsp_err_next;

`ifdef APB_MST_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [15:0] wait_cnt_inc;
    assign wait_cnt_inc = wait_cnt_reg + 16'd1;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg     <= IDLE;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_vld_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            rsp_vld_reg   <= rsp_vld_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt_reg  <= wait_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        rsp_vld_next   = rsp_vld_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
`ifdef APB_MST_TIMEOUT_EN
        wait_cnt_next  = wait_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (req_vld) begin
                    pwrite_next  = req_write;
                    paddr_next   = req_addr;
                    pwdata_next  = req_wdata;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
`ifdef APB_MST_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_next = pwrite_reg ? '0 : prdata;
                    rsp_err_next   = pslverr;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_vld_next   = 1'b1;
                    state_next     = RESP;
                end
`ifdef APB_MST_TIMEOUT_EN
                // A late pready on the final wait cycle still completes normally.
                else if (wait_cnt_inc == TIMEOUT_CNT) begin
                    wait_cnt_next  = wait_cnt_inc;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_vld_next   = 1'b1;
                    state_next     = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                end
`endif
            end
            RESP: begin
                if (rsp_rdy) begin
                    rsp_vld_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_rdy   = (state_reg == IDLE);
    assign psel      = psel_reg;
    assign penable   = penable_reg;
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_vld   = rsp_vld_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed self-checking bench for apb_req_master; define APB_MST_TIMEOUT_EN to exercise the abort path.
module tb_apb_req_master;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_vld, req_rdy, req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_vld, rsp_rdy, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_req_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(8)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
        req_vld = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        step();
        req_vld = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        repeat (2) step();
        presetn = 1'b1;
        step();
        n_checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== '0) begin
            n_fail++; $display("FAIL reset_apb: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, want all 0", psel, penable, pwrite, paddr, pwdata);
        end
        n_checks++;
        if ({rsp_vld, rsp_err, rsp_rdata} !== '0 || req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_rsp: got rsp_vld=%b err=%b rdata=%h req_rdy=%b, want 0/0/0/1", rsp_vld, rsp_err, rsp_rdata, req_rdy);
        end
        $display("reset: req_rdy=%b psel=%b rsp_vld=%b", req_rdy, psel, rsp_vld);
    endtask

    task automatic test_write();
        pready = 1'b1; pslverr = 1'b0; rsp_rdy = 1'b1;
        issue(1'b1, 16'h0000, 32'h0000_1234);
        n_checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 16'h0000 || pwdata !== 32'h1234) begin
            n_fail++; $display("FAIL write_setup: got sel/en/wr=%b%b%b paddr=%h pwdata=%h, want 101 0000 00001234", psel, penable, pwrite, paddr, pwdata);
        end
        step();
        n_checks++;
        if ({psel, penable} !== 2'b11 || pwdata !== 32'h1234 || rsp_vld !== 1'b0) begin
            n_fail++; $display("FAIL write_access: got sel/en=%b%b pwdata=%h rsp_vld=%b, want 11 00001234 0", psel, penable, pwdata, rsp_vld);
        end
        step();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin
            n_fail++; $display("FAIL write_rsp: got vld=%b err=%b rdata=%h psel=%b, want 1 0 00000000 0", rsp_vld, rsp_err, rsp_rdata, psel);
        end
        step();
        n_checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL write_idle: got rsp_vld=%b req_rdy=%b, want 0 1", rsp_vld, req_rdy);
        end
        $display("write addr=0000 data=00001234 -> rsp_err=%b rdata=%h", rsp_err, rsp_rdata);
    endtask

    task automatic test_read();
        bit rdy_bad = 0;
        pready = 1'b1; pslverr = 1'b0; rsp_rdy = 1'b1; prdata = 32'h0000_0003;
        issue(1'b0, 16'h0008, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            if (req_rdy !== 1'b0) rdy_bad = 1;
            if (i < 2) step();
        end
        n_checks++;
        if (rdy_bad) begin
            n_fail++; $display("FAIL read_req_rdy: req_rdy went 1 during transaction, want 0");
        end
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h3 || rsp_err !== 1'b0 || pwrite !== 1'b0 || paddr !== 16'h0008) begin
            n_fail++; $display("FAIL read_rsp: got vld=%b rdata=%h err=%b pwrite=%b paddr=%h, want 1 00000003 0 0 0008", rsp_vld, rsp_rdata, rsp_err, pwrite, paddr);
        end
        step();
        n_checks++;
        if (req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL read_idle: got req_rdy=%b, want 1", req_rdy);
        end
        $display("read addr=0008 -> rsp_rdata=%h rsp_err=%b", rsp_rdata, rsp_err);
    endtask

    task automatic test_wait_states();
        bit unstable = 0;
        rsp_rdy = 1'b1; pready = 1'b0; pslverr = 1'b1; prdata = 32'h1111_1111;
        issue(1'b0, 16'h0104, 32'h0);
        step();
        for (int i = 0; i < 6; i++) begin
            if ({psel, penable} !== 2'b11 || paddr !== 16'h0104 || pwrite !== 1'b0 || rsp_vld !== 1'b0) unstable = 1;
            if (i == 5) begin
                pready = 1'b1; prdata = 32'hDEAD_BEEF;
            end
            step();
        end
        n_checks++;
        if (unstable) begin
            n_fail++; $display("FAIL wait_stable: ACCESS outputs changed or early rsp_vld during 6 ACCESS cycles");
        end
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b1 || psel !== 1'b0) begin
            n_fail++; $display("FAIL wait_rsp: got vld=%b rdata=%h err=%b psel=%b, want 1 deadbeef 1 0", rsp_vld, rsp_rdata, rsp_err, psel);
        end
        $display("read addr=0104 with 5 waits -> rsp_rdata=%h rsp_err=%b", rsp_rdata, rsp_err);
        pslverr = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bit held_bad = 0;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_5555; rsp_rdy = 1'b0;
        issue(1'b0, 16'h0040, 32'h0);
        step(); step();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h5555) begin
            n_fail++; $display("FAIL bp_rsp: got vld=%b rdata=%h, want 1 00005555", rsp_vld, rsp_rdata);
        end
        prdata = 32'h0;
        req_vld = 1'b1; req_write = 1'b1; req_addr = 16'h0044; req_wdata = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h5555 || rsp_err !== 1'b0 || req_rdy !== 1'b0 || psel !== 1'b0) held_bad = 1;
        end
        n_checks++;
        if (held_bad) begin
            n_fail++; $display("FAIL bp_hold: response not held or request accepted while rsp_rdy=0");
        end
        rsp_rdy = 1'b1;
        step();
        n_checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b1 || psel !== 1'b0) begin
            n_fail++; $display("FAIL bp_handshake: got rsp_vld=%b req_rdy=%b psel=%b, want 0 1 0", rsp_vld, req_rdy, psel);
        end
        step();
        req_vld = 1'b0;
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 16'h0044 || pwdata !== 32'hCAFE_0001 || pwrite !== 1'b1) begin
            n_fail++; $display("FAIL bp_next: got sel=%b en=%b paddr=%h pwdata=%h pwr=%b, want 1 0 0044 cafe0001 1", psel, penable, paddr, pwdata, pwrite);
        end
        step(); step(); step();
        $display("backpressure: next write accepted, paddr=%h req_rdy=%b", paddr, req_rdy);
    endtask

    task automatic test_timeout();
        int cyc = 0;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFF_FFFF; rsp_rdy = 1'b1;
        issue(1'b0, 16'h0030, 32'h0);
        step();
`ifdef APB_MST_TIMEOUT_EN
        while (rsp_vld !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cyc != 8 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++; $display("FAIL timeout_abort: got cycles=%0d err=%b rdata=%h psel=%b pen=%b, want 8 1 00000000 0 0", cyc, rsp_err, rsp_rdata, psel, penable);
        end
        $display("timeout: abort after %0d wait cycles rsp_err=%b", cyc, rsp_err);
        step();
`else
        for (int i = 0; i < 120; i++) begin
            if ({psel, penable} === 2'b11 && rsp_vld === 1'b0) cyc++;
            step();
        end
        n_checks++;
        if (cyc != 120) begin
            n_fail++; $display("FAIL no_timeout: ACCESS held with no rsp_vld for %0d of 120 cycles, want 120", cyc);
        end
        $display("no timeout: psel held %0d cycles", cyc);
`endif
    endtask

    task automatic test_reset_mid();
        bit vld_seen = 0;
        pready = 1'b0; rsp_rdy = 1'b1;
        if (req_rdy === 1'b1) begin
            issue(1'b0, 16'h0010, 32'h0);
            step();
        end
        presetn = 1'b0;
        #1;
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_async: got psel=%b penable=%b, want 0 0", psel, penable);
        end
        pready = 1'b1;
        step(); step();
        presetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_vld !== 1'b0 || psel !== 1'b0) vld_seen = 1;
        end
        n_checks++;
        if (vld_seen || req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_after: spurious rsp_vld/psel=%b or req_rdy=%b, want 0 1", vld_seen, req_rdy);
        end
        prdata = 32'h0000_A5A5;
        issue(1'b0, 16'h0020, 32'h0);
        step(); step();
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hA5A5 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_recover: got vld=%b rdata=%h err=%b, want 1 0000a5a5 0", rsp_vld, rsp_rdata, rsp_err);
        end
        $display("reset mid-access: recovery read rdata=%h", rsp_rdata);
        step();
    endtask

    initial begin
        presetn = 1'b0;
        req_vld = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_rdy = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
